// File: rtl/figure_pkg.sv
// Shared types and geometry for the figure-recognition pipeline.
// Coordinates and boxes here are also consumed by the intersection counter.
package figure_pkg;

    localparam int DISPLAY_WIDTH  = 640;
    localparam int DISPLAY_HEIGHT = 480;
    localparam int COORD_W        = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t top;
        coord_t bottom;
        coord_t left;
        coord_t right;
    } box_t;

    localparam coord_t X_LAST = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(DISPLAY_HEIGHT - 1);
    localparam coord_t Y_END  = coord_t'(DISPLAY_HEIGHT);

    // Empty accumulator: inverted box so the first row min/max wins.
    localparam box_t ACC_INIT = '{top: Y_LAST, bottom: '0, left: X_LAST, right: '0};
    localparam box_t OUT_INIT = '{top: '0, bottom: Y_LAST, left: '0, right: X_LAST};

    function automatic coord_t cmin(input coord_t a, input coord_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic coord_t cmax(input coord_t a, input coord_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/figure_locate_if.sv
// Camera stream in, committed bounding box out.
// master = camera/bench side, slave = figure_locate.
interface figure_locate_if;
    import figure_pkg::*;

    logic   vsync;
    logic   href;
    logic   clken;
    logic   bin;
    coord_t line_top;
    coord_t line_bottom;
    coord_t line_left;
    coord_t line_right;
    logic   fig_found;

    modport master (
        output vsync, href, clken, bin,
        input  line_top, line_bottom, line_left, line_right, fig_found
    );

    modport slave (
        input  vsync, href, clken, bin,
        output line_top, line_bottom, line_left, line_right, fig_found
    );

endinterface

// File: rtl/figure_locate_run_filter.sv
// Horizontal run-length filter: only pixels inside runs of RUN_MIN or
// more foreground pixels are reported as qualified.
module run_filter
    import figure_pkg::*;
#(
    parameter int RUN_MIN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       bin,
    input  coord_t     x_cnt,
    input  logic       row_end,
    output logic       qual,
    output coord_t     run_start,
    output logic [3:0] cnt_inc
);

    localparam logic [3:0] RMAX = 4'(RUN_MIN);

    logic [3:0] run_len;
    logic [3:0] len_nx;
    logic       first;

    always_comb begin
        len_nx = 4'd0;
        if (bin) begin
            len_nx = (run_len == RMAX) ? RMAX : run_len + 4'd1;
        end
    end

    // The pixel that first reaches RUN_MIN credits the whole run at once.
    assign qual      = clken & bin & (len_nx == RMAX);
    assign first     = (run_len != RMAX);
    assign cnt_inc   = qual ? (first ? RMAX : 4'd1) : 4'd0;
    assign run_start = x_cnt - coord_t'(RUN_MIN - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_len <= 4'd0;
        end else if (row_end) begin
            run_len <= 4'd0;
        end else if (clken) begin
            run_len <= len_nx;
        end
    end

endmodule

// File: rtl/figure_locate.sv
// Tracks the bounding box of noise-filtered foreground pixels per frame
// and commits it on vsync fall for use during the following frame.
module figure_locate
    import figure_pkg::*;
#(
    parameter int RUN_MIN = 4,
    parameter int ROW_MIN = 8
) (
    input  logic            clk,
    input  logic            reset,
    figure_locate_if.slave  bus
);

    coord_t     x_cnt, y_cnt;
    logic       vsync_d, vs_low, armed;
    logic       pix_en, row_last, row_end, commit;

    logic       qual;
    coord_t     run_start;
    logic [3:0] cnt_inc;

    coord_t     row_left, row_right;
    logic [9:0] row_cnt;
    coord_t     left_nx, right_nx;
    logic [9:0] cnt_nx;
    logic [10:0] cnt_sum;
    logic       row_ok;

    box_t       acc, line;
    logic       acc_any, found;

    logic       unused_href;
    assign unused_href = bus.href;

    assign pix_en   = bus.vsync & bus.clken & (y_cnt < Y_END);
    assign row_last = pix_en & (x_cnt == X_LAST);
    assign row_end  = row_last | ~bus.vsync;
    assign commit   = ~bus.vsync & vsync_d;

    run_filter #(.RUN_MIN(RUN_MIN)) u_run (
        .clk       (clk),
        .reset     (reset),
        .clken     (pix_en),
        .bin       (bus.bin),
        .x_cnt     (x_cnt),
        .row_end   (row_end),
        .qual      (qual),
        .run_start (run_start),
        .cnt_inc   (cnt_inc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (!bus.vsync) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_en) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + coord_t'(1);
            end else begin
                x_cnt <= x_cnt + coord_t'(1);
            end
        end
    end

    // Row totals including the current pixel, so the closing pixel counts.
    always_comb begin
        cnt_sum  = {1'b0, row_cnt} + 11'(cnt_inc);
        cnt_nx   = cnt_sum[10] ? 10'h3ff : cnt_sum[9:0];
        left_nx  = qual ? cmin(row_left, run_start) : row_left;
        right_nx = qual ? x_cnt : row_right;
        row_ok   = (cnt_nx >= 10'(ROW_MIN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_left  <= X_LAST;
            row_right <= '0;
            row_cnt   <= '0;
        end else if (row_end) begin
            row_left  <= X_LAST;
            row_right <= '0;
            row_cnt   <= '0;
        end else if (pix_en) begin
            row_left  <= left_nx;
            row_right <= right_nx;
            row_cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= ACC_INIT;
            acc_any <= 1'b0;
        end else if (commit) begin
            acc     <= ACC_INIT;
            acc_any <= 1'b0;
        end else if (row_last && row_ok) begin
            acc.top    <= cmin(acc.top, y_cnt);
            acc.bottom <= y_cnt;
            acc.left   <= cmin(acc.left, left_nx);
            acc.right  <= cmax(acc.right, right_nx);
            acc_any    <= 1'b1;
        end
    end

    // vs_low blocks arming on the vsync_d=0 left behind by a mid-frame reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d <= 1'b0;
            vs_low  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            vsync_d <= bus.vsync;
            vs_low  <= vs_low | ~bus.vsync;
            armed   <= armed | (bus.vsync & ~vsync_d & vs_low);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line  <= OUT_INIT;
            found <= 1'b0;
        end else if (commit && armed) begin
            if (acc_any) begin
                line  <= acc;
                found <= 1'b1;
            end else begin
                found <= 1'b0;
            end
        end
    end

    assign bus.line_top    = line.top;
    assign bus.line_bottom = line.bottom;
    assign bus.line_left   = line.left;
    assign bus.line_right  = line.right;
    assign bus.fig_found   = found;

endmodule

// File: doc/figure_locate.md
# figure_locate

Upstream stage of the intersection counter in the figure-recognition pipeline. Scans the binarized camera stream, rejects speckle noise with a horizontal run-length filter and a per-row pixel threshold, and tracks the bounding box of the foreground figure. The box is committed once per frame, at vsync fall, on `line_top/bottom/left/right`. These outputs drive the intersection counter during the following frame.

## Interface
- `DISPLAY_WIDTH`, 640: active pixels per row.
- `DISPLAY_HEIGHT`, 480: active rows per frame.
- `RUN_MIN`, 4: minimum length of a horizontal foreground run (range 2..15) for its pixels to count.
- `ROW_MIN`, 8: minimum qualified pixels in a row (range 1..DISPLAY_WIDTH) for the row to join the box.
- `clk` input 1: pixel clock.
- `reset` input 1: asynchronous, active-high.
- `vsync` input 1: high during active frame, low during vertical blanking.
- `href` input 1: line valid. Not used for qualification; kept for interface uniformity.
- `clken` input 1: pixel strobe. One pixel per cycle with clken=1.
- `bin` input 1: binarized pixel, 1 = foreground (figure), 0 = background.
- `line_top` output 11: topmost qualified row.
- `line_bottom` output 11: bottommost qualified row.
- `line_left` output 11: leftmost x of any qualified run in a qualified row.
- `line_right` output 11: rightmost x of any qualified run in a qualified row.
- `fig_found` output 1: 1 if the last committed frame contained at least one qualified row.

## Operation
- Pixel position counters `x_cnt`/`y_cnt`, 11 bits:
  - Cleared while vsync=0.
  - On clken, x increments; when x = DISPLAY_WIDTH-1 it wraps to 0 and y increments.
  - y saturates at DISPLAY_HEIGHT. Pixels with y ≥ DISPLAY_HEIGHT are ignored.
- Run filter, per pixel on clken:
  - `run_len` (4 bits) increments while bin=1, saturating at RUN_MIN, and clears on bin=0 and on row wrap. Runs never carry across rows.
  - A pixel is qualified when it brings `run_len` to RUN_MIN, or when `run_len` is already at RUN_MIN and bin=1.
  - On the pixel that first reaches RUN_MIN:
    - run start = x_cnt-(RUN_MIN-1);
    - `row_left` = min(row_left, run start);
    - `row_cnt` += RUN_MIN.
  - On each later qualified pixel, `row_cnt` += 1.
  - On every qualified pixel, `row_right` = x_cnt.
  - `row_cnt` (10 bits) saturates at 1023.
- Row close, on the clken at x = DISPLAY_WIDTH-1:
  - The current pixel's contribution is included, computed combinationally.
  - If the row count ≥ ROW_MIN:
    - `acc_top` = min(acc_top, y);
    - `acc_bottom` = y;
    - `acc_left` = min(acc_left, row_left);
    - `acc_right` = max(acc_right, row_right);
    - `acc_any` = 1.
  - `row_*` registers then reinitialize: left = DISPLAY_WIDTH-1, right = 0, cnt = 0.
- Commit, on the cycle where vsync=0 and registered `vsync_d`=1:
  - If `armed` and `acc_any` = 1: copy the accumulators to the `line_*` outputs and set fig_found=1.
  - If `armed` and `acc_any` = 0: set fig_found=0; the `line_*` outputs hold their previous values.
  - If not `armed`: no output changes.
  - In all cases, the accumulators reinitialize: top = DISPLAY_HEIGHT-1, bottom = 0, left = DISPLAY_WIDTH-1, right = 0, any = 0.
- Truncated row (vsync falls before x wraps): the partial row is discarded, never closed.
- `armed`:
  - Cleared by reset.
  - Set on the first vsync rise (vsync=1, vsync_d=0) after reset.
  - A frame that was in progress when reset released is therefore never committed.

## Timing
- Reset values:
  - line_top = 0, line_bottom = DISPLAY_HEIGHT-1;
  - line_left = 0, line_right = DISPLAY_WIDTH-1;
  - fig_found = 0;
  - all counters, accumulators and `armed` at their init values; vsync_d = 0.
- Outputs are registered and update only at the commit edge. They are stable for the whole following frame.
- Latency: commit happens 1 clk after vsync is first sampled low.
- A single-pixel qualifying run is impossible for RUN_MIN ≥ 2. Run-start subtraction never underflows, because a run of RUN_MIN ending at x implies x ≥ RUN_MIN-1.
- Row close and commit never coincide, since vsync=0 clears the counters. If vsync drops on the same edge as the last pixel's clken, that pixel is dropped: vsync=0 takes priority.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous reset).

## Structure
- Shared package `figure_pkg`:
  - `DISPLAY_WIDTH`, `DISPLAY_HEIGHT`;
  - `COORD_W` = 11;
  - the coordinate type also used by the intersection counter.
- Sub-module `run_filter`:
  - inputs clk, reset, clken, bin, x_cnt, row_end;
  - outputs qualified-pixel strobe, run start, and count increment.
- Top level holds the position counters, row and frame accumulators, armed/commit logic, and output registers.

## Test plan
All scenarios use 640x480 frames, RUN_MIN=4, ROW_MIN=8, with one idle frame after reset to arm.
- Solid rectangle x 200..299, y 100..219 -> 1 clk after vsync fall: top=100, bottom=219, left=200, right=299, fig_found=1.
- Same rectangle plus 200 random 1–3-pixel specks elsewhere -> identical box.
- Rectangle plus a single 6-pixel run at y=50, x 10..15 -> top stays 100 (row count 6 < 8), left stays 200.
- Row wrap: bin=1 at x 637..639 of row 300 and x 0..1 of row 301, nothing else -> no qualified run; fig_found=0, `line_*` unchanged from the prior frame.
- Empty frame after a valid frame -> fig_found=0, `line_*` hold 100/219/200/299.
- Reset pulse at row 240 -> outputs 0/479/0/639 immediately. The next vsync fall commits nothing; the following full frame commits the rectangle.
